audio_i2s_tx: RTL

//  Frame-timed sink for the PSG's stereo mix. It generates the per-frame next_sample strobe
//  and latches the signed 23-bit left/right accumulators at each frame boundary.

---
 rtl/audio_pkg.sv | 9 +
 rtl/audio_sample_conv.sv | 28 ++
 rtl/audio_i2s_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared widths and sample type for the I2S audio transmitter.
package audio_pkg;
  localparam int SAMPLE_W   = 23;  // producer mix accumulator width
  localparam int PCM_W      = 16;  // DAC word width
  localparam int SLOT_W     = 32;  // BCK periods per channel slot
  localparam int FRAME_BITS = 64;  // BCK periods per stereo frame

  typedef logic signed [PCM_W-1:0] pcm_t;
endpackage

// File: rtl/audio_sample_conv.sv
// Scales a signed 23-bit mix sample down to 16-bit PCM.
// Build option: define AUDIO_SATURATE_EN to clamp out-of-range values
// instead of letting them wrap.
module audio_sample_conv
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] in,
  input  logic [2:0]          shift,
  output pcm_t                pcm
);

  logic signed [SAMPLE_W-1:0] s;

  // Arithmetic shift, then either clamp to the 16-bit range or keep the low bits
  always_comb begin
    s   = $signed(in) >>> shift;
    pcm = s[PCM_W-1:0];
`ifdef AUDIO_SATURATE_EN
    // In range only when every bit above bit 15 matches the sign bit
    if (!s[SAMPLE_W-1] && (s[SAMPLE_W-2:PCM_W-1] != '0)) begin
      pcm = 16'sh7FFF;
    end else if (s[SAMPLE_W-1] && (s[SAMPLE_W-2:PCM_W-1] != '1)) begin
      pcm = 16'sh8000;
    end
`endif
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Frame-rate master and Philips I2S serializer for the PSG stereo mix.
// Build option: AUDIO_SATURATE_EN (passed to audio_sample_conv) selects
// clamping instead of wrap-around on 16-bit overflow.
//
// Producer contract (no ready/valid): next_sample pulses for one clk at each
// frame wrap, and left_in/right_in are sampled in that same clk. The producer
// must present the next pair within 2*BCK_DIV*64-2 clk of the pulse and hold
// it until the following pulse.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCK_DIV   = 4,  // clk cycles per BCK half-period (>=2)
  parameter int OUT_SHIFT = 6   // right shift before 16-bit conversion (0..7)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  output logic                next_sample,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int              DIV_W       = $clog2(BCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCK_DIV - 1);
  localparam logic [5:0]      BIT_WRAP    = 6'd0;
  localparam logic [5:0]      BIT_LAST    = 6'(FRAME_BITS - 1);
  localparam logic [5:0]      BIT_RIGHT0  = 6'(SLOT_W);
  localparam logic [5:0]      BIT_LRCK_HI = 6'(SLOT_W - 1);
  localparam logic [4:0]      PAD_FIRST   = 5'(PCM_W);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [5:0]       bit_nxt;
  logic             fall;
  pcm_t             left_pcm;
  pcm_t             right_pcm;
  pcm_t             held_right;
  logic [PCM_W-1:0] left_sr;
  logic [PCM_W-1:0] right_sr;
  logic [PCM_W-1:0] left_sr_nxt;
  logic [PCM_W-1:0] right_sr_nxt;
  logic             data_nxt;

  audio_sample_conv u_conv_left (
    .in    (left_in),
    .shift (3'(OUT_SHIFT)),
    .pcm   (left_pcm)
  );

  audio_sample_conv u_conv_right (
    .in    (right_in),
    .shift (3'(OUT_SHIFT)),
    .pcm   (right_pcm)
  );

  // A fall is the divider wrap while BCK is high; everything serial advances on it
  assign fall    = (div_cnt == DIV_LAST) && i2s_bck;
  assign bit_nxt = bit_cnt + 6'd1;

  // Next shift-register contents and serial bit for the upcoming bit position
  always_comb begin
    left_sr_nxt  = left_sr;
    right_sr_nxt = right_sr;
    if (bit_nxt == BIT_WRAP) begin
      left_sr_nxt = left_pcm;
    end else if (!bit_nxt[5]) begin
      left_sr_nxt = {left_sr[PCM_W-2:0], 1'b0};
    end
    // Right word comes from the pair captured at the wrap, never from the live input
    if (bit_nxt == BIT_RIGHT0) begin
      right_sr_nxt = held_right;
    end else if (bit_nxt[5]) begin
      right_sr_nxt = {right_sr[PCM_W-2:0], 1'b0};
    end
    if (bit_nxt[4:0] >= PAD_FIRST) begin
      data_nxt = 1'b0;
    end else if (bit_nxt[5]) begin
      data_nxt = right_sr_nxt[PCM_W-1];
    end else begin
      data_nxt = left_sr_nxt[PCM_W-1];
    end
  end

  // Divider, bit counter, frame strobe, sample capture and registered I2S pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= BIT_LAST;
      left_sr     <= '0;
      right_sr    <= '0;
      held_right  <= '0;
      next_sample <= 1'b0;
      i2s_bck     <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_data    <= 1'b0;
    end else begin
      next_sample <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        i2s_bck <= ~i2s_bck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        bit_cnt  <= bit_nxt;
        left_sr  <= left_sr_nxt;
        right_sr <= right_sr_nxt;
        i2s_data <= data_nxt;
        if (bit_nxt == BIT_WRAP) begin
          next_sample <= 1'b1;
          held_right  <= right_pcm;
        end
        // Word select switches one BCK ahead of each slot's MSB
        if (bit_nxt == BIT_LRCK_HI) begin
          i2s_lrck <= 1'b1;
        end else if (bit_nxt == BIT_LAST) begin
          i2s_lrck <= 1'b0;
        end
      end
    end
  end

endmodule
